// File: rtl/thresholding_axi_rb.sv
// thresholding_axi_rb: AXI-Lite programmed multi-threshold stream unit; define THRESHOLDING_READBACK_EN for threshold read-back
module thresholding_axi_rb #(
  parameter int N = 2,
  parameter int K = 8,
  parameter int C = 4,
  parameter int PE = 2,
  parameter int SIGNED = 1,
  parameter int BIAS = 0,
  localparam int CF = C / PE,
  localparam int LP = $clog2(PE),
  localparam int LF = $clog2(CF),
  localparam int ADDR_BITS = LF + LP + N + 2,
  localparam int O_BITS = BIAS >= 0 ? $clog2(2**N + BIAS) : 1 + $clog2(-BIAS >= 2**(N-1) ? -BIAS : 2**N + BIAS),
  localparam int IW = (PE * K + 7) / 8 * 8,
  localparam int OW = (PE * O_BITS + 7) / 8 * 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axilite_AWVALID,
  output logic                 s_axilite_AWREADY,
  input  logic [ADDR_BITS-1:0] s_axilite_AWADDR,
  input  logic                 s_axilite_WVALID,
  output logic                 s_axilite_WREADY,
  input  logic [31:0]          s_axilite_WDATA,
  input  logic [3:0]           s_axilite_WSTRB,
  output logic                 s_axilite_BVALID,
  input  logic                 s_axilite_BREADY,
  output logic [1:0]           s_axilite_BRESP,
  input  logic                 s_axilite_ARVALID,
  output logic                 s_axilite_ARREADY,
  input  logic [ADDR_BITS-1:0] s_axilite_ARADDR,
  output logic                 s_axilite_RVALID,
  input  logic                 s_axilite_RREADY,
  output logic [31:0]          s_axilite_RDATA,
  output logic [1:0]           s_axilite_RRESP,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IW-1:0]        s_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OW-1:0]        m_axis_tdata
);
  localparam int T = 2**N - 1;
  localparam int PW = LP > 0 ? LP : 1;
  localparam int FW = LF > 0 ? LF : 1;
  localparam int DW = PE * K;
  localparam int RW = PE * O_BITS;

  if (C % PE != 0) begin : g_bad_cfg
    $fatal(1, "thresholding_axi_rb: C must be a multiple of PE");
  end

  function automatic void dec(input logic [ADDR_BITS-1:0] a, output logic ok,
                              output logic [FW-1:0] f, output logic [PW-1:0] p, output logic [N-1:0] i);
    logic [ADDR_BITS-1:0] pa, fa;
    pa = (a >> (2 + N)) & ADDR_BITS'((1 << LP) - 1);
    fa = a >> (2 + N + LP);
    i = a[2+:N];
    p = PW'(pa);
    f = FW'(fa);
    ok = i != N'(T) && pa < ADDR_BITS'(PE) && fa < ADDR_BITS'(CF);
  endfunction

  function automatic logic ge(input logic [K-1:0] a, input logic [K-1:0] b);
    return SIGNED != 0 ? ($signed(a) >= $signed(b)) : (a >= b);
  endfunction

  logic [K-1:0] thr [PE][CF][T];

  logic                 aw_busy, w_busy, w_ok;
  logic [ADDR_BITS-1:0] aw_addr;
  logic [31:0]          w_data;
  logic [FW-1:0]        w_f;
  logic [PW-1:0]        w_p;
  logic [N-1:0]         w_i;

  always_comb dec(aw_addr, w_ok, w_f, w_p, w_i);

  assign s_axilite_AWREADY = !aw_busy;
  assign s_axilite_WREADY  = !w_busy;
  assign s_axilite_BVALID  = aw_busy && w_busy;
  assign s_axilite_BRESP   = w_ok ? 2'b00 : 2'b10;

  always_ff @(posedge clk)
    if (rst) begin
      aw_busy <= 1'b0;
      w_busy  <= 1'b0;
    end else if (s_axilite_BVALID && s_axilite_BREADY) begin
      aw_busy <= 1'b0;
      w_busy  <= 1'b0;
    end else begin
      if (s_axilite_AWVALID && !aw_busy) begin
        aw_busy <= 1'b1;
        aw_addr <= s_axilite_AWADDR;
      end
      if (s_axilite_WVALID && !w_busy) begin
        w_busy <= 1'b1;
        w_data <= s_axilite_WDATA;
      end
    end

  // Storage is deliberately not reset; an out-of-range commit writes nothing.
  always_ff @(posedge clk)
    if (s_axilite_BVALID && s_axilite_BREADY && w_ok) thr[w_p][w_f][w_i] <= w_data[K-1:0];

  logic r_valid;
  assign s_axilite_RVALID  = r_valid;
  assign s_axilite_ARREADY = !r_valid;

  always_ff @(posedge clk)
    if (rst) r_valid <= 1'b0;
    else if (s_axilite_ARVALID && !r_valid) r_valid <= 1'b1;
    else if (r_valid && s_axilite_RREADY) r_valid <= 1'b0;

`ifdef THRESHOLDING_READBACK_EN
  logic          r_ok;
  logic [FW-1:0] r_f;
  logic [PW-1:0] r_p;
  logic [N-1:0]  r_i;
  logic [K-1:0]  r_thr;
  logic [31:0]   r_word, r_data;
  logic [1:0]    r_resp;

  always_comb begin
    dec(s_axilite_ARADDR, r_ok, r_f, r_p, r_i);
    r_thr  = thr[r_p][r_f][r_i];
    r_word = SIGNED != 0 ? 32'($signed(r_thr)) : 32'(r_thr);
  end

  always_ff @(posedge clk)
    if (s_axilite_ARVALID && !r_valid) begin
      r_data <= r_ok ? r_word : '0;
      r_resp <= r_ok ? 2'b00 : 2'b10;
    end

  assign s_axilite_RDATA = r_data;
  assign s_axilite_RRESP = r_resp;
`else
  assign s_axilite_RDATA = '1;
  assign s_axilite_RRESP = 2'b00;
`endif

  logic          en, s1_vld, s2_vld, a_vld, b_vld;
  logic [FW-1:0] fold, s1_fold;
  logic [DW-1:0] s1_dat;
  logic [RW-1:0] res, s2_dat, a_dat, b_dat;
  logic [N-1:0]  cnt;

  assign en            = !a_vld;
  assign s_axis_tready = en;
  assign m_axis_tvalid = b_vld;
  assign m_axis_tdata  = OW'(b_dat);

  // Thresholds are read here, when stage 2 registers, so a same-edge commit is not seen.
  always_comb begin
    res = '0;
    cnt = '0;
    for (int p = 0; p < PE; p++) begin
      cnt = '0;
      for (int j = 0; j < T; j++) cnt = cnt + N'(ge(s1_dat[p*K+:K], thr[p][s1_fold][j]));
      res[p*O_BITS+:O_BITS] = O_BITS'(cnt) + O_BITS'(BIAS);
    end
  end

  // B drives the output; A catches the one result still in flight when B stalls.
  always_ff @(posedge clk)
    if (rst) begin
      fold   <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      a_vld  <= 1'b0;
      b_vld  <= 1'b0;
    end else if (en) begin
      s1_vld <= s_axis_tvalid;
      s2_vld <= s1_vld;
      s2_dat <= res;
      if (s_axis_tvalid) begin
        s1_dat  <= DW'(s_axis_tdata);
        s1_fold <= fold;
        fold    <= fold == FW'(CF - 1) ? '0 : fold + 1'b1;
      end
      if (!b_vld || m_axis_tready) begin
        b_vld <= s2_vld;
        b_dat <= s2_dat;
      end else if (s2_vld) begin
        a_vld <= 1'b1;
        a_dat <= s2_dat;
      end
    end else if (m_axis_tready) begin
      b_dat <= a_dat;
      a_vld <= 1'b0;
    end

  logic unused;
  assign unused = ^{s_axilite_WSTRB, w_data, aw_addr, s_axilite_ARADDR, s_axis_tdata};
endmodule
